graphics_compositor: RTL and testbench

Parametrised, pipelined pixel compositor for the VGA path. It merges NUM_LAYERS per-pixel driver outputs by fixed priority over a background colour. It also generates the built-in colour-bar test pattern and adds a frame-synchronised flash effect for screen transitions (line clear, game won/lost). All outputs are registered and the latency is fixed, so the result and its row/col tag arrive together at the VGA output mux.

---
 rtl/graphics_compositor_if.sv | 34 +++
 rtl/graphics_compositor.sv | 205 ++++++++++++++++++++
 tb/tb_graphics_compositor.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/graphics_compositor_if.sv
// Pixel bus between the VGA timing/driver side and the compositor.
// The master drives the pixel stream and control; the slave is the compositor.
interface graphics_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 24
);
  logic [9:0]                          VGA_row;
  logic [9:0]                          VGA_col;
  logic                                pixel_valid;
  logic                                frame_start;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]  layer_color;
  logic [NUM_LAYERS-1:0]               layer_active;
  logic [NUM_LAYERS-1:0]               layer_enable;
  logic [COLOR_W-1:0]                  bg_color;
  logic                                testpattern_active;
  logic                                flash_req;
  logic [COLOR_W-1:0]                  output_color;
  logic                                output_valid;
  logic [9:0]                          out_row;
  logic [9:0]                          out_col;
  logic                                flash_busy;

  modport master (
    output VGA_row, VGA_col, pixel_valid, frame_start, layer_color,
           layer_active, layer_enable, bg_color, testpattern_active, flash_req,
    input  output_color, output_valid, out_row, out_col, flash_busy
  );

  modport slave (
    input  VGA_row, VGA_col, pixel_valid, frame_start, layer_color,
           layer_active, layer_enable, bg_color, testpattern_active, flash_req,
    output output_color, output_valid, out_row, out_col, flash_busy
  );
endinterface

// File: rtl/graphics_compositor.sv
// Pipelined pixel compositor: priority layer merge over a background,
// colour-bar test pattern, and a frame-aligned flash (inversion) effect.
// Fixed LATENCY from input sample to output; no stalls.
module graphics_compositor #(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 24,
  parameter int LATENCY      = 2,
  parameter int FLASH_FRAMES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  graphics_compositor_if.slave  bus
);

  localparam int FL_W = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARMED, ON, OFF} flash_state_t;

  // ---------------- flash FSM ----------------
  flash_state_t     state_q, state_d;
  logic [FL_W-1:0]  frames_left_q, frames_left_d;
  logic             busy_q;

  // State register; busy is registered from the next state so it tracks state_q exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      frames_left_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  // Next state: only IDLE->ARMED may happen mid-frame, all else waits for frame_start
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    case (state_q)
      IDLE: begin
        if (bus.flash_req) state_d = ARMED;
      end
      ARMED: begin
        if (bus.frame_start) begin
          state_d       = ON;
          frames_left_d = FL_W'(FLASH_FRAMES - 1);
        end
      end
      ON, OFF: begin
        if (bus.frame_start) begin
          if (frames_left_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d       = (state_q == ON) ? OFF : ON;
            frames_left_d = frames_left_q - FL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.flash_busy = busy_q;

  // ---------------- stage 1: input capture ----------------
  logic [9:0]                          s1_row_q, s1_col_q;
  logic                                s1_valid_q, s1_tp_q;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0]  s1_color_q;
  logic [NUM_LAYERS-1:0]               s1_active_q, s1_enable_q;
  logic [COLOR_W-1:0]                  s1_bg_q;

  // Register every pixel input so compose works from a clean registered view
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_tp_q     <= 1'b0;
      s1_color_q  <= '0;
      s1_active_q <= '0;
      s1_enable_q <= '0;
      s1_bg_q     <= '0;
    end else begin
      s1_row_q    <= bus.VGA_row;
      s1_col_q    <= bus.VGA_col;
      s1_valid_q  <= bus.pixel_valid;
      s1_tp_q     <= bus.testpattern_active;
      s1_color_q  <= bus.layer_color;
      s1_active_q <= bus.layer_active;
      s1_enable_q <= bus.layer_enable;
      s1_bg_q     <= bus.bg_color;
    end
  end

  // ---------------- stage 2: compose ----------------
  logic [COLOR_W-1:0] layer_pick;
  logic [3:0]         bar;
  logic [23:0]        bar_rgb;
  logic [COLOR_W-1:0] tp_color;
  logic [COLOR_W-1:0] base_color;
  logic [COLOR_W-1:0] s2_color_d, s2_color_q;
  logic               s2_valid_q;
  logic [9:0]         s2_row_q, s2_col_q;

  // Priority merge: later (higher-index) qualifying layers override earlier ones
  always_comb begin
    layer_pick = s1_bg_q;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (s1_active_q[k] && s1_enable_q[k]) layer_pick = s1_color_q[k];
    end
  end

  // 80-pixel-wide bars; col >= 640 yields bar >= 8 which falls back to background
  assign bar = 4'(s1_col_q / 10'd80);

  // Colour-bar pattern: R on bars 0,1,4,5; G on bars 0..3; B on even bars
  always_comb begin
    bar_rgb         = 24'h0;
    bar_rgb[23:16]  = {8{(bar == 4'd0) || (bar == 4'd1) || (bar == 4'd4) || (bar == 4'd5)}};
    bar_rgb[15:8]   = {8{bar < 4'd4}};
    bar_rgb[7:0]    = {8{~bar[0]}};
    if ((s1_row_q >= 10'd240) || (bar >= 4'd8)) tp_color = s1_bg_q;
    else                                          tp_color = COLOR_W'(bar_rgb);
  end

  // Final stage-2 colour: blank when invalid, inverted while the flash is ON
  always_comb begin
    base_color = s1_tp_q ? tp_color : layer_pick;
    s2_color_d = '0;
    if (s1_valid_q) s2_color_d = (state_q == ON) ? ~base_color : base_color;
  end

  // Stage-2 register carries colour with its tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_color_q <= '0;
      s2_valid_q <= 1'b0;
      s2_row_q   <= '0;
      s2_col_q   <= '0;
    end else begin
      s2_color_q <= s2_color_d;
      s2_valid_q <= s1_valid_q;
      s2_row_q   <= s1_row_q;
      s2_col_q   <= s1_col_q;
    end
  end

  // ---------------- stages 3..LATENCY: delay line ----------------
  generate
    if (LATENCY > 2) begin : g_delay
      localparam int DL = LATENCY - 2;
      logic [COLOR_W-1:0] dl_color_q [DL];
      logic               dl_valid_q [DL];
      logic [9:0]         dl_row_q   [DL];
      logic [9:0]         dl_col_q   [DL];

      for (genvar gi = 0; gi < DL; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          // First delay stage follows the compose stage
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              dl_color_q[0] <= '0;
              dl_valid_q[0] <= 1'b0;
              dl_row_q[0]   <= '0;
              dl_col_q[0]   <= '0;
            end else begin
              dl_color_q[0] <= s2_color_q;
              dl_valid_q[0] <= s2_valid_q;
              dl_row_q[0]   <= s2_row_q;
              dl_col_q[0]   <= s2_col_q;
            end
          end
        end else begin : g_tail
          // Remaining stages shift the previous stage along
          always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
              dl_color_q[gi] <= '0;
              dl_valid_q[gi] <= 1'b0;
              dl_row_q[gi]   <= '0;
              dl_col_q[gi]   <= '0;
            end else begin
              dl_color_q[gi] <= dl_color_q[gi-1];
              dl_valid_q[gi] <= dl_valid_q[gi-1];
              dl_row_q[gi]   <= dl_row_q[gi-1];
              dl_col_q[gi]   <= dl_col_q[gi-1];
            end
          end
        end
      end

      assign bus.output_color = dl_color_q[DL-1];
      assign bus.output_valid = dl_valid_q[DL-1];
      assign bus.out_row      = dl_row_q[DL-1];
      assign bus.out_col      = dl_col_q[DL-1];
    end else begin : g_direct
      assign bus.output_color = s2_color_q;
      assign bus.output_valid = s2_valid_q;
      assign bus.out_row      = s2_row_q;
      assign bus.out_col      = s2_col_q;
    end
  endgenerate

endmodule

// File: tb/tb_graphics_compositor.sv
// Bench for graphics_compositor: two instances (LATENCY 2 / FLASH_FRAMES 3 and
// LATENCY 4 / FLASH_FRAMES 6) share one stimulus stream and are compared every
// cycle against a frame-counting reference model; directed literal checks pin it.
module tb_graphics_compositor;
  localparam int NL = 4;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]             row, col;
  logic                   valid, fs, tp, req;
  logic [NL-1:0][CW-1:0]  lcol;
  logic [NL-1:0]          lact, len;
  logic [CW-1:0]          bg;

  graphics_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) if_a ();
  graphics_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) if_b ();

  assign if_a.VGA_row = row;            assign if_b.VGA_row = row;
  assign if_a.VGA_col = col;            assign if_b.VGA_col = col;
  assign if_a.pixel_valid = valid;      assign if_b.pixel_valid = valid;
  assign if_a.frame_start = fs;         assign if_b.frame_start = fs;
  assign if_a.layer_color = lcol;       assign if_b.layer_color = lcol;
  assign if_a.layer_active = lact;      assign if_b.layer_active = lact;
  assign if_a.layer_enable = len;       assign if_b.layer_enable = len;
  assign if_a.bg_color = bg;            assign if_b.bg_color = bg;
  assign if_a.testpattern_active = tp;  assign if_b.testpattern_active = tp;
  assign if_a.flash_req = req;          assign if_b.flash_req = req;

  graphics_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .LATENCY(2), .FLASH_FRAMES(3))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  graphics_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .LATENCY(4), .FLASH_FRAMES(6))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Collected outputs, indexed by instance
  logic [CW-1:0] oc [2];
  logic          ov [2];
  logic [9:0]    orow [2];
  logic [9:0]    ocol [2];
  logic          ob [2];
  assign oc[0] = if_a.output_color;  assign oc[1] = if_b.output_color;
  assign ov[0] = if_a.output_valid;  assign ov[1] = if_b.output_valid;
  assign orow[0] = if_a.out_row;     assign orow[1] = if_b.out_row;
  assign ocol[0] = if_a.out_col;     assign ocol[1] = if_b.out_col;
  assign ob[0] = if_a.flash_busy;    assign ob[1] = if_b.flash_busy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ff_n  [2] = '{3, 6};
  int lat_n [2] = '{2, 4};
  int mode   [2];   // 0 idle, 1 waiting for a frame, 2 running
  int nframe [2];   // 1-based frame number within the running sequence
  logic busy_exp [2];

  typedef struct packed {
    logic [CW-1:0] c;
    logic          v;
    logic [9:0]    r;
    logic [9:0]    cl;
  } rec_t;
  rec_t hist [2][8];

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [CW-1:0] model_color(input logic inv);
    logic [CW-1:0] base;
    int b;
    if (!valid) return '0;
    if (tp) begin
      b = int'(col) / 80;
      if (row >= 10'd240 || b >= 8) base = bg;
      else                          base = bars[b];
    end else begin
      base = bg;
      for (int k = NL - 1; k >= 0; k--) begin
        if (lact[k] && len[k]) begin
          base = lcol[k];
          break;
        end
      end
    end
    return inv ? ~base : base;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mode[d] = 0; nframe[d] = 0; busy_exp[d] = 1'b0;
        for (int i = 0; i < 8; i++) hist[d][i] = '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        rec_t r;
        if (mode[d] == 0) begin
          if (req) mode[d] = 1;
        end else if (fs) begin
          if (mode[d] == 1) begin
            mode[d] = 2; nframe[d] = 1;
          end else begin
            nframe[d]++;
            if (nframe[d] > ff_n[d]) mode[d] = 0;
          end
        end
        busy_exp[d] = (mode[d] != 0);
        r.c  = model_color(mode[d] == 2 && (nframe[d] % 2) == 1);
        r.v  = valid;
        r.r  = row;
        r.cl = col;
        for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
        hist[d][0] = r;
      end
    end
  end

  // Per-cycle compare of both instances against the model
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        rec_t e;
        e = hist[d][lat_n[d]-1];
        chk($sformatf("dut%0d.color", d), 32'(oc[d]),   32'(e.c));
        chk($sformatf("dut%0d.valid", d), 32'(ov[d]),   32'(e.v));
        chk($sformatf("dut%0d.row", d),   32'(orow[d]), 32'(e.r));
        chk($sformatf("dut%0d.col", d),   32'(ocol[d]), 32'(e.cl));
        chk($sformatf("dut%0d.busy", d),  32'(ob[d]),   32'(busy_exp[d]));
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Four frames after arming; optional second flash_req mid frame 2
  task automatic run_frames(input bit extra_req);
    for (int f = 1; f <= 4; f++) begin
      fs = 1'b1; row = 10'd0; col = 10'd0;
      tick();
      fs = 1'b0; col = 10'd1;
      chk($sformatf("busy_frame%0d", f), 32'(if_a.flash_busy), (f <= 3) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("flash_frame%0d", f), 32'(if_a.output_color),
          ((f % 2) == 1 && f <= 3) ? 32'hFF00FF : 32'h00FF00);
      if (extra_req && f == 2) req = 1'b1;
      tick();
      req = 1'b0;
      repeat (2) tick();
    end
  endtask

  int tp_cols [9] = '{0, 100, 170, 250, 330, 420, 500, 600, 700};
  logic [23:0] tp_exp [9] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h405060};

  initial begin
    row = '0; col = '0; valid = 1'b0; fs = 1'b0; tp = 1'b0; req = 1'b0;
    lcol = '0; lact = '0; len = '1; bg = 24'h405060;
    repeat (3) tick();
    chk("reset_color", 32'(if_a.output_color), 32'h0);
    chk("reset_valid", 32'(if_a.output_valid), 32'h0);
    chk("reset_busy",  32'(if_a.flash_busy),   32'h0);
    rst = 1'b0;
    tick();

    // Priority merge
    lcol[1] = 24'h112233; lcol[2] = 24'hAABBCC; lact = 4'b0110; len = 4'b1111;
    row = 10'd5; col = 10'd7; valid = 1'b1;
    tick(); tick();
    chk("prio_top",   32'(if_a.output_color), 32'hAABBCC);
    chk("prio_row",   32'(if_a.out_row),      32'd5);
    chk("prio_col",   32'(if_a.out_col),      32'd7);
    chk("prio_valid", 32'(if_a.output_valid), 32'd1);
    len = 4'b1011;
    tick(); tick();
    chk("prio_masked", 32'(if_a.output_color), 32'h112233);
    lact = 4'b0000;
    tick(); tick();
    chk("prio_bg", 32'(if_a.output_color), 32'h405060);
    len = 4'b1111;

    // Test pattern
    tp = 1'b1; row = 10'd10;
    for (int i = 0; i < 9; i++) begin
      col = 10'(tp_cols[i]);
      tick(); tick();
      chk($sformatf("tp_col%0d", tp_cols[i]), 32'(if_a.output_color), 32'(tp_exp[i]));
    end
    row = 10'd300; col = 10'd50;
    tick(); tick();
    chk("tp_row300", 32'(if_a.output_color), 32'h405060);
    valid = 1'b0;
    tick(); tick();
    chk("tp_invalid", 32'(if_a.output_color), 32'h0);
    valid = 1'b1; tp = 1'b0;

    // Flash sequence, request mid-frame
    lact = 4'b0001; lcol[0] = 24'h00FF00;
    row = 10'd100; col = 10'd20; req = 1'b1;
    tick();
    req = 1'b0;
    chk("busy_rise", 32'(if_a.flash_busy), 32'd1);
    tick();
    run_frames(1'b0);

    // Request coincident with frame_start: arms only
    fs = 1'b1; req = 1'b1; row = 10'd0; col = 10'd0;
    tick();
    fs = 1'b0; req = 1'b0; col = 10'd1;
    chk("simul_busy", 32'(if_a.flash_busy), 32'd1);
    tick();
    chk("simul_not_inverted", 32'(if_a.output_color), 32'h00FF00);
    repeat (3) tick();
    run_frames(1'b1);

    // Reset in the middle of an ON frame
    req = 1'b1;
    tick();
    req = 1'b0; fs = 1'b1; row = 10'd0; col = 10'd0;
    tick();
    fs = 1'b0; col = 10'd1;
    tick();
    chk("pre_reset_inverted", 32'(if_a.output_color), 32'hFF00FF);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_color_a", 32'(if_a.output_color), 32'h0);
    chk("async_rst_color_b", 32'(if_b.output_color), 32'h0);
    chk("async_rst_valid_a", 32'(if_a.output_valid), 32'h0);
    chk("async_rst_busy_a",  32'(if_a.flash_busy),   32'h0);
    chk("async_rst_busy_b",  32'(if_b.flash_busy),   32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    row = 10'd33; col = 10'd44;
    tick();
    chk("post_rst_not_yet", 32'(if_a.output_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(if_a.output_valid), 32'd1);
    chk("post_rst_color", 32'(if_a.output_color), 32'h00FF00);
    chk("post_rst_row",   32'(if_a.out_row),      32'd33);

    // Random stream
    for (int n = 0; n < 2500; n++) begin
      valid = ($urandom_range(0, 7) != 0);
      tp    = ($urandom_range(0, 2) == 0);
      row   = 10'($urandom_range(0, 599));
      col   = 10'($urandom_range(0, 1023));
      for (int k = 0; k < NL; k++) lcol[k] = 24'($urandom);
      lact  = 4'($urandom);
      bg    = 24'($urandom);
      fs    = ($urandom_range(0, 29) == 0);
      if (fs) begin row = '0; col = '0; end
      req   = ($urandom_range(0, 149) == 0);
      if ((n % 200) == 0) len = 4'($urandom);
      tick();
    end
    fs = 1'b0; req = 1'b0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
